mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the instruction-fetch requester (IF) and the data requester (MEM stage).
//
// Serialises accesses IDLE -> BUSY -> RESP, so every access takes at least
// three cycles and two accesses never overlap. The selected request is
// latched into the registered mem_* outputs and held for the whole access.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   if_req_i, if_addr_i       fetch request/address (held until if_ack_o)
//   if_rdata_o, if_ack_o      fetched word, one-cycle completion pulse
//   d_req_i, d_we_i           data request, 1=store 0=load
//   d_addr_i, d_wdata_i       data address / store data (held until d_ack_o)
//   d_rdata_o, d_ack_o        load data, one-cycle completion pulse
//   mem_req_o, mem_we_o       memory request / write enable
//   mem_addr_o, mem_wdata_o   registered memory address / write data
//   mem_rdata_i, mem_ack_i    memory read data, one-cycle completion
//   stall_o                   pipeline hold while any request is pending
//   err_o                     pulses with the ack of a timed-out access
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise data always wins over fetch.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          gnt_d_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic          pick_d;
  logic          any_req;
  logic          timeout;

`ifdef MEM_ARB_RR_EN
  // 1 when the data port won the most recent grant
  logic last_d_q;

  assign pick_d = d_req_i & (~if_req_i | ~last_d_q);
`else
  assign pick_d = d_req_i;
`endif

  assign any_req = if_req_i | d_req_i;

  // Last permitted BUSY cycle with no ack: give up at this edge
  assign timeout = (cnt_q == CNT_LAST) & ~mem_ack_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_req) state_d = BUSY;
      BUSY: if (mem_ack_i | timeout) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_d_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_d_q     <= pick_d;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            mem_we_o    <= pick_d & d_we_i;
            mem_addr_o  <= pick_d ? d_addr_i : if_addr_i;
            mem_wdata_o <= pick_d ? d_wdata_i : '0;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= pick_d;
`endif
          end
        end
        BUSY: begin
          if (mem_ack_i | timeout) begin
            // timed-out reads return zero; stores leave d_rdata_o alone
            mem_we_o <= 1'b0;
            err_q    <= ~mem_ack_i;
            if (!gnt_d_q)
              if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
            else if (!mem_we_o)
              d_rdata_o  <= mem_ack_i ? mem_rdata_i : '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: err_q <= err_q;
        default: ;
      endcase
    end
  end

  assign mem_req_o = (state_q == BUSY);
  assign if_ack_o  = (state_q == RESP) & ~gnt_d_q;
  assign d_ack_o   = (state_q == RESP) & gnt_d_q;
  assign err_o     = (state_q == RESP) & err_q;
  assign stall_o   = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// Runs with TIMEOUT_CYC=4; expectations follow MEM_ARB_RR_EN if defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        err;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_d;
  logic [31:0] exp_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .d_req_i(d_req), .d_we_i(d_we),
    .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack),
    .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .stall_o(stall), .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ack = 0;
    tick(); tick();
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    total++; if ({if_ack, d_ack, err, stall} !== 4'b0) begin bad++; $display("FAIL rst_flags got=%b want=0000", {if_ack, d_ack, err, stall}); end
    total++; if ({if_rdata, d_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", {if_rdata, d_rdata}); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_if_only();
    if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL t1_stall got=%b want=1", stall); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL t1_req_early got=%b want=0", mem_req); end
    tick();
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL t1_mem_req got=%b want=1", mem_req); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL t1_mem_addr got=%h want=10", mem_addr); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL t1_mem_we got=%b want=0", mem_we); end
    mem_ack = 1; mem_rdata = 32'h2002_0005;
    tick();
    mem_ack = 0;
    @(negedge clk);
    total++; if (if_ack !== 1'b1 || d_ack !== 1'b0) begin bad++; $display("FAIL t1_ack got=%b%b want=10", if_ack, d_ack); end
    total++; if (if_rdata !== 32'h2002_0005) begin bad++; $display("FAIL t1_rdata got=%h want=20020005", if_rdata); end
    total++; if ({stall, err, mem_req} !== 3'b0) begin bad++; $display("FAIL t1_resp_flags got=%b want=000", {stall, err, mem_req}); end
    exp_i = 32'h2002_0005;
    if_req = 0;
    tick();
    @(negedge clk);
    total++; if ({if_ack, mem_req} !== 2'b0) begin bad++; $display("FAIL t1_idle got=%b want=00", {if_ack, mem_req}); end
  endtask

  // Both requesters raise req together; first_d selects the expected winner.
  task automatic both_req(input logic first_d, input logic [31:0] ia,
                          input logic [31:0] da, input logic [31:0] v0,
                          input logic [31:0] v1, input string tag);
    logic [31:0] ea [2];
    logic [31:0] ev [2];
    logic        ed [2];
    ed[0] = first_d; ed[1] = ~first_d;
    ea[0] = first_d ? da : ia; ea[1] = first_d ? ia : da;
    ev[0] = v0; ev[1] = v1;
    if_req = 1; if_addr = ia;
    d_req = 1; d_we = 0; d_addr = da;
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge clk);
      total++; if (mem_addr !== ea[k]) begin bad++; $display("FAIL %s_addr%0d got=%h want=%h", tag, k, mem_addr, ea[k]); end
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s_busy_stall%0d got=%b want=1", tag, k, stall); end
      mem_ack = 1; mem_rdata = ev[k];
      tick();
      mem_ack = 0;
      @(negedge clk);
      total++; if ({d_ack, if_ack} !== {ed[k], ~ed[k]}) begin bad++; $display("FAIL %s_ack%0d got=%b%b want=%b%b", tag, k, d_ack, if_ack, ed[k], ~ed[k]); end
      if (ed[k]) begin
        exp_d = ev[k];
        total++; if (d_rdata !== ev[k]) begin bad++; $display("FAIL %s_drdata%0d got=%h want=%h", tag, k, d_rdata, ev[k]); end
        d_req = 0;
      end else begin
        exp_i = ev[k];
        total++; if (if_rdata !== ev[k]) begin bad++; $display("FAIL %s_irdata%0d got=%h want=%h", tag, k, if_rdata, ev[k]); end
        if_req = 0;
      end
      tick();
      @(negedge clk);
      total++; if (stall !== (k == 0)) begin bad++; $display("FAIL %s_idle_stall%0d got=%b want=%b", tag, k, stall, k == 0); end
    end
  endtask

  task automatic test_priority();
    both_req(1'b1, 32'h20, 32'h100, 32'hD00D_0001, 32'h1F1F_0002, "t2");
  endtask

  task automatic test_rr();
    logic fd;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    tick();
    mem_ack = 1; mem_rdata = 32'hAAAA_0003;
    tick();
    mem_ack = 0;
    @(negedge clk);
    total++; if (d_ack !== 1'b1 || d_rdata !== 32'hAAAA_0003) begin bad++; $display("FAIL t3_pre got=%b/%h want=1/aaaa0003", d_ack, d_rdata); end
    exp_d = 32'hAAAA_0003;
    d_req = 0;
    tick();
`ifdef MEM_ARB_RR_EN
    fd = 1'b0;
`else
    fd = 1'b1;
`endif
    both_req(fd, 32'h24, 32'h104, 32'hBBBB_0004, 32'hCCCC_0005, "t3");
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hCAFE_F00D;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({mem_req, mem_we} !== 2'b11) begin bad++; $display("FAIL t4_req_we%0d got=%b want=11", i, {mem_req, mem_we}); end
      total++; if (mem_wdata !== 32'hCAFE_F00D || mem_addr !== 32'h8) begin bad++; $display("FAIL t4_wdata%0d got=%h@%h want=cafef00d@8", i, mem_wdata, mem_addr); end
      if (i == 2) begin mem_ack = 1; mem_rdata = 32'h5555_5555; end
      tick();
    end
    mem_ack = 0;
    @(negedge clk);
    total++; if ({d_ack, if_ack, err} !== 3'b100) begin bad++; $display("FAIL t4_ack got=%b want=100", {d_ack, if_ack, err}); end
    total++; if (d_rdata !== exp_d) begin bad++; $display("FAIL t4_rdata got=%h want=%h", d_rdata, exp_d); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL t4_we_drop got=%b want=0", mem_we); end
    d_req = 0; d_we = 0;
    tick();
  endtask

  task automatic test_timeout();
    if_req = 1; if_addr = 32'h40;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (mem_req !== 1'b1 || if_ack !== 1'b0) begin bad++; $display("FAIL t5_busy%0d got=%b%b want=10", i, mem_req, if_ack); end
      tick();
    end
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    total++; if ({if_ack, err} !== 2'b11) begin bad++; $display("FAIL t5_ack_err got=%b want=11", {if_ack, err}); end
    total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL t5_rdata got=%h want=0", if_rdata); end
    exp_i = 32'h0;
    if_req = 0;
    tick();
    @(negedge clk);
    total++; if ({mem_req, if_ack, d_ack, err} !== 4'b0) begin bad++; $display("FAIL t5_late_ack got=%b want=0000", {mem_req, if_ack, d_ack, err}); end
    tick();
    mem_ack = 0;
    @(negedge clk);
    total++; if ({mem_req, if_ack, if_rdata} !== 34'h0) begin bad++; $display("FAIL t5_after got=%b%b/%h want=00/0", mem_req, if_ack, if_rdata); end
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 0; d_addr = 32'h200;
    tick();
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL t6_busy got=%b want=1", mem_req); end
    rst = 1;
    tick();
    @(negedge clk);
    total++; if ({mem_req, d_ack, err} !== 3'b0) begin bad++; $display("FAIL t6_abort got=%b want=000", {mem_req, d_ack, err}); end
    total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL t6_rdata_rst got=%h want=0", d_rdata); end
    rst = 0;
    tick();
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin bad++; $display("FAIL t6_regrant got=%b@%h want=1@200", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 32'h0000_600D;
    tick();
    mem_ack = 0;
    @(negedge clk);
    total++; if (d_ack !== 1'b1 || d_rdata !== 32'h600D) begin bad++; $display("FAIL t6_serve got=%b/%h want=1/600d", d_ack, d_rdata); end
    d_req = 0;
    tick();
  endtask

  initial begin
    exp_d = 0;
    exp_i = 0;
    test_reset();
    test_if_only();
    test_priority();
    test_rr();
    test_store();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
